// File: rtl/popcount_pkg.sv
// Shared types and constants for the sequential population counter.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

endpackage

// File: rtl/popcount_seq_chunk_popcount.sv
// Combinational population count of one CHUNK-bit slice.
module chunk_popcount #(
    parameter int CHUNK = 4,
    localparam int PC_W = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] d,
    output logic [PC_W-1:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + PC_W'(d[i]);
        end
    end

endmodule

// File: rtl/popcount_seq.sv
// Multi-cycle ones/zeros counter: scans CHUNK bits per clock and
// reports the sum with a one-cycle done pulse.
module popcount_seq
    import popcount_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] one
);

    localparam int N    = WIDTH / CHUNK;
    localparam int CI_W = (N > 1) ? $clog2(N) : 1;
    localparam int PC_W = $clog2(CHUNK + 1);
    localparam logic [CI_W-1:0] LAST = CI_W'(N - 1);

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shr;
    logic [CI_W-1:0]  cidx;
    logic [CNT_W-1:0] acc;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] sum;

    chunk_popcount #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .d  (shift[CHUNK-1:0]),
        .cnt(pc)
    );

    // A full-width chunk leaves nothing to shift in.
    generate
        if (CHUNK == WIDTH) begin : g_noshift
            assign shr = '0;
        end else begin : g_shift
            assign shr = {{CHUNK{1'b0}}, shift[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign sum = acc + CNT_W'(pc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            shift <= '0;
            cidx  <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            one   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shift <= (mode == MODE_ZEROS) ? ~a : a;
                        acc   <= '0;
                        cidx  <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= sum;
                    shift <= shr;
                    cidx  <= cidx + CI_W'(1);
                    if (cidx == LAST) begin
                        one   <= sum;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_seq.sv
// Directed and table-driven checks for popcount_seq across four
// parameterisations sharing one clock and reset.
module tb_popcount_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  start = '0;
    logic        mode = 1'b0;
    logic [31:0] a = '0;

    logic       busy0, done0, busy1, done1, busy2, done2, busy3, done3;
    logic [4:0] one0, one1, one2;
    logic [5:0] one3;

    int         sel = 0;
    logic       busy_s, done_s;
    int         one_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    popcount_seq #(.WIDTH(16), .CHUNK(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode),
        .a(a[15:0]), .busy(busy0), .done(done0), .one(one0)
    );
    popcount_seq #(.WIDTH(16), .CHUNK(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode),
        .a(a[15:0]), .busy(busy1), .done(done1), .one(one1)
    );
    popcount_seq #(.WIDTH(16), .CHUNK(16)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode),
        .a(a[15:0]), .busy(busy2), .done(done2), .one(one2)
    );
    popcount_seq #(.WIDTH(32), .CHUNK(8)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .mode(mode),
        .a(a), .busy(busy3), .done(done3), .one(one3)
    );

    always_comb begin
        busy_s = busy0;
        done_s = done0;
        one_s  = int'(one0);
        case (sel)
            1: begin busy_s = busy1; done_s = done1; one_s = int'(one1); end
            2: begin busy_s = busy2; done_s = done2; one_s = int'(one2); end
            3: begin busy_s = busy3; done_s = done3; one_s = int'(one3); end
            default: ;
        endcase
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation on instance inst and check result, latency and busy length.
    task automatic run_op(input int inst, input logic [31:0] av, input logic m,
                          input int exp_one, input int exp_lat, input string name);
        int lat;
        int bc;
        sel = inst;
        a = av;
        mode = m;
        start[inst] = 1'b1;
        tick();
        start[inst] = 1'b0;
        a = ~av;
        mode = ~m;
        lat = 0;
        bc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy_s) bc++;
            if (done_s) begin
                lat = c;
                break;
            end
            tick();
        end
        check({name, " one"}, one_s, exp_one);
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy cycles"}, bc, exp_lat - 1);
        tick();
        check({name, " done drop"}, int'(done_s), 0);
    endtask

    typedef struct {
        logic [15:0] av;
        logic        m;
        int          exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int dn;
        int bc;
        int lat;
        logic [31:0] r;
        logic        rm;
        int          ex;

        vecs[0] = '{16'hFFFF, 1'b0, 16};
        vecs[1] = '{16'h333F, 1'b0, 10};
        vecs[2] = '{16'hAAAA, 1'b0, 8};
        vecs[3] = '{16'h0000, 1'b0, 0};
        vecs[4] = '{16'h0000, 1'b1, 16};
        vecs[5] = '{16'h333F, 1'b1, 6};
        vecs[6] = '{16'hFFFF, 1'b1, 0};

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset busy", int'(busy0), 0);
        check("reset done", int'(done0), 0);
        check("reset one", int'(one0), 0);

        for (int i = 0; i < 7; i++) begin
            run_op(0, {16'h0, vecs[i].av}, vecs[i].m, vecs[i].exp, 5,
                   $sformatf("vec%0d", i));
        end

        // Starts during BUSY and DONE must be ignored.
        sel = 0;
        a = 32'hFFFF;
        mode = 1'b0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        a = 32'h0001;
        dn = 0;
        bc = 0;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            if (busy0) bc++;
            if (done0) begin
                dn++;
                if (lat == 0) lat = c;
            end
            start[0] = (c == 2 || c == 5);
            tick();
        end
        start[0] = 1'b0;
        check("ignore done count", dn, 1);
        check("ignore latency", lat, 5);
        check("ignore busy cycles", bc, 4);
        check("ignore one", int'(one0), 16);

        // Reset in the middle of a scan.
        a = 32'hFFFF;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst busy", int'(busy0), 0);
        check("midrst one", int'(one0), 0);
        dn = int'(done0);
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done0) dn++;
        end
        check("midrst no done", dn, 0);
        run_op(0, 32'h000F, 1'b0, 4, 5, "after rst");

        // Parameter sweep against a reference popcount.
        for (int k = 0; k < 4; k++) begin
            r  = $urandom;
            rm = 1'($urandom_range(0, 1));
            ex = $countones(r[15:0]);
            if (rm) ex = 16 - ex;
            run_op(1, r, rm, ex, 17, $sformatf("c1 %0d", k));
            r  = $urandom;
            rm = 1'($urandom_range(0, 1));
            ex = $countones(r[15:0]);
            if (rm) ex = 16 - ex;
            run_op(2, r, rm, ex, 2, $sformatf("c16 %0d", k));
            r  = $urandom;
            rm = 1'($urandom_range(0, 1));
            ex = $countones(r);
            if (rm) ex = 32 - ex;
            run_op(3, r, rm, ex, 5, $sformatf("w32 %0d", k));
        end
        run_op(3, 32'hFFFFFFFF, 1'b0, 32, 5, "w32 full");
        run_op(3, 32'hFFFFFFFF, 1'b1, 0, 5, "w32 zeros");
        run_op(2, 32'h0000FFFF, 1'b0, 16, 2, "c16 full");
        run_op(1, 32'h00008001, 1'b1, 14, 17, "c1 edges");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/popcount_seq.md
# popcount_seq

Parametrised, multi-cycle ones/zeros counter, the sequential successor to our 16-bit combinational ones counter. It accepts a WIDTH-bit operand on a start pulse and scans it CHUNK bits per clock. It accumulates the count and presents the result with a one-cycle done pulse. It sits beside datapath blocks that need a population count of wide words without a single deep adder tree on the critical path.

## Interface
- WIDTH, default 16: operand width; must be ≥ 2.
- CHUNK, default 4: bits consumed per BUSY cycle. WIDTH must be a multiple of CHUNK, and 1 ≤ CHUNK ≤ WIDTH.
- CNT_W, derived, $clog2(WIDTH+1): result width. It is 5 for WIDTH=16 and must hold the value WIDTH exactly.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  sampled with start. 0 = count ones, 1 = count zeros.
- a  input  WIDTH  operand; sampled with start only.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- one  output  CNT_W  result; holds its value until the next done.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - When start=1, load the shift register with a, or with ~a when mode=1.
  - Clear the accumulator and the chunk counter, then go to BUSY.
  - When start=0, stay in IDLE.
- **BUSY**
  - Each cycle, add the popcount of shift[CHUNK-1:0] to the accumulator.
  - Shift the register right by CHUNK bits and increment the chunk counter.
  - After the N-th add, where N = WIDTH/CHUNK, go to DONE and load one with the final sum.
- **DONE**
  - done=1 for exactly this one cycle; the next state is always IDLE.
- start while busy=1 or done=1 is ignored. No queueing; a later start must be reissued in IDLE.
- a and mode are don't-care outside the start-sampling cycle. Changing them mid-scan has no effect.
- Arithmetic is unsigned. The accumulator is CNT_W bits and never overflows, since the maximum is WIDTH.
- Reset (rst_n=0 at a clock edge) has priority over everything, in any state including mid-scan:
  - state goes to IDLE;
  - busy=0, done=0, one=0;
  - the accumulator, shift register and chunk counter are cleared.
- A start asserted in the same cycle as rst_n=0 is lost.

## Timing
- Edge 0 samples start=1 in IDLE.
- busy is high after edges 0 through N-1, i.e. for N cycles.
- After edge N: state is DONE, done=1, busy=0, and one is valid.
- After edge N+1: state is IDLE and done=0.
- Latency from the start edge to done is N+1 cycles. Minimum start-to-start spacing is N+2 cycles.
- With WIDTH=16 and CHUNK=4: N=4, done is seen in the 5th cycle after start, and the next start can be accepted 6 cycles after the previous one.
- CHUNK=WIDTH degenerates to N=1, so done comes 2 cycles after start.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package popcount_pkg contains:
  - the state typedef (IDLE, BUSY, DONE);
  - the MODE_ONES=0 and MODE_ZEROS=1 constants.
- Sub-module chunk_popcount: purely combinational. It takes a CHUNK-bit input and produces a $clog2(CHUNK+1)-bit count, and is instantiated once.
- The top level holds the FSM, shift register, chunk counter, accumulator and result register.

## Test plan
Defaults are WIDTH=16, CHUNK=4 unless noted.
- Reset check: rst_n=0 for 2 cycles, then release → busy=0, done=0, one=0.
- Basic ones counts, each with mode=0:
  - a=16'hFFFF → one=16, with done exactly 5 cycles after start and busy high for 4 cycles;
  - a=16'h333F → one=10;
  - a=16'hAAAA → one=8;
  - a=16'h0000 → one=0.
- Zeros mode, mode=1:
  - a=16'h0000 → one=16;
  - a=16'h333F → one=6;
  - a=16'hFFFF → one=0.
- Ignored start: start a=16'hFFFF, then pulse start with a=16'h0001 during BUSY and again during DONE → a single done, one=16, busy drops after 4 cycles.
- Mid-scan reset: start a=16'hFFFF, assert rst_n=0 after 2 BUSY cycles → next cycle busy=0, one=0, and no done.
  - A new start with a=16'h000F then gives one=4.
- Parameter sweep: CHUNK=1, CHUNK=16, and WIDTH=32 with CHUNK=8, with random operands checked against a reference popcount.
  - Expected done latency is 17, 2 and 5 cycles respectively.
  - WIDTH=32 with a=32'hFFFFFFFF gives one=32 (CNT_W=6).
